// File: rtl/md_pkg.sv
// Shared constants and state encoding for the intra mode-decision prefilter
// fetch path. The fetch stage and the prefilter accumulators use the same
// window numbering.
package md_pkg;

  // Sequencer states of md_fetch_ctrl
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_SCAN = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  // Window index range driven to the fetch stage for one 8x8 block
  localparam logic [5:0] MD_CNT_FIRST   = 6'd5;
  localparam logic [5:0] MD_CNT_LAST    = 6'd40;
  localparam int         MD_WIN_PER_BLK = 36;

endpackage

// File: rtl/md_fetch_align.sv
// One-cycle alignment stage: turns the window issue strobes into strobes that
// line up with the fetch stage's registered x1/x2/x3 outputs.
module md_fetch_align (
  input  logic clk,
  input  logic rstn,
  input  logic issue,
  input  logic issue_first,
  input  logic issue_last,
  output logic x_vld,
  output logic blk_first,
  output logic blk_last
);

  // Delay the issue strobes by one cycle to match the fetch stage register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_vld     <= 1'b0;
      blk_first <= 1'b0;
      blk_last  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every strobe samples the pre-edge issue values.
      x_vld     <= issue;
      blk_first <= issue_first;
      blk_last  <= issue_last;
    end
  end

endmodule

// File: rtl/md_fetch_ctrl.sv
// Fetch-stage sequencer for the intra mode-decision prefilter. A job reads
// blk_num_i+1 consecutive RF lines starting at base_i and scans windows 5..40
// of each line. Optional macro MD_FETCH_CTRL_STALL_EN adds stall_i, which
// holds the window counter in SCAN.
module md_fetch_ctrl
  import md_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int RD_LAT = 1,
  parameter int BLK_W  = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [BLK_W-1:0]  blk_num_i,
  output logic              busy_o,
  output logic              rf_rd_en_o,
  output logic [ADDR_W-1:0] rf_rd_addr_o,
  output logic [5:0]        cnt_o,
  output logic              x_vld_o,
  output logic              blk_first_o,
  output logic              blk_last_o,
  output logic              done_o
`ifdef MD_FETCH_CTRL_STALL_EN
  ,
  input  logic              stall_i
`endif
);

  // WAIT covers RD_LAT-1 cycles; the down-counter is loaded with RD_LAT-2.
  localparam logic [2:0] WAIT_INIT = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

  md_state_e         state;
  logic [ADDR_W-1:0] base_q;
  logic [BLK_W-1:0]  num_q;
  logic [BLK_W-1:0]  blk_idx;
  logic [2:0]        wait_cnt;
  logic              stall;
  logic              issue;
  logic              issue_first;
  logic              issue_last;

`ifdef MD_FETCH_CTRL_STALL_EN
  assign stall = stall_i;
`else
  assign stall = 1'b0;
`endif

  // A window is issued in every SCAN cycle that is not held
  assign issue       = (state == ST_SCAN) && !stall;
  assign issue_first = issue && (cnt_o == MD_CNT_FIRST);
  assign issue_last  = issue && (cnt_o == MD_CNT_LAST);

  // Job sequencer with outputs registered alongside the state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      base_q       <= '0;
      num_q        <= '0;
      blk_idx      <= '0;
      wait_cnt     <= '0;
      busy_o       <= 1'b0;
      rf_rd_en_o   <= 1'b0;
      rf_rd_addr_o <= '0;
      cnt_o        <= '0;
      done_o       <= 1'b0;
    end else begin
      // NOTE: one-cycle outputs default low and are raised only on the edge
      // entering their state, so they are registered yet coincide with it.
      rf_rd_en_o   <= 1'b0;
      rf_rd_addr_o <= '0;
      done_o       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            base_q       <= base_i;
            num_q        <= blk_num_i;
            blk_idx      <= '0;
            busy_o       <= 1'b1;
            rf_rd_en_o   <= 1'b1;
            rf_rd_addr_o <= base_i;
            state        <= ST_READ;
          end
        end
        ST_READ: begin
          if (RD_LAT > 1) begin
            wait_cnt <= WAIT_INIT;
            state    <= ST_WAIT;
          end else begin
            cnt_o <= MD_CNT_FIRST;
            state <= ST_SCAN;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 3'd0) begin
            cnt_o <= MD_CNT_FIRST;
            state <= ST_SCAN;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ST_SCAN: begin
          if (issue) begin
            if (cnt_o == MD_CNT_LAST) begin
              cnt_o <= '0;
              if (blk_idx == num_q) begin
                done_o <= 1'b1;
                state  <= ST_DONE;
              end else begin
                blk_idx      <= blk_idx + 1'b1;
                rf_rd_en_o   <= 1'b1;
                rf_rd_addr_o <= base_q + ADDR_W'(blk_idx) + ADDR_W'(1);
                state        <= ST_READ;
              end
            end else begin
              cnt_o <= cnt_o + 6'd1;
            end
          end
        end
        ST_DONE: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          cnt_o  <= '0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  md_fetch_align u_align (
    .clk         (clk),
    .rstn        (rstn),
    .issue       (issue),
    .issue_first (issue_first),
    .issue_last  (issue_last),
    .x_vld       (x_vld_o),
    .blk_first   (blk_first_o),
    .blk_last    (blk_last_o)
  );

endmodule

// File: tb/tb_md_fetch_ctrl.sv
// Bench for md_fetch_ctrl: two instances (RD_LAT=1 and RD_LAT=3) share the
// stimulus; a position-based job model predicts every output each cycle and
// literal cycle-number checks pin the model.
module tb_md_fetch_ctrl;

  localparam int LAT [2] = '{1, 3};
  localparam int WIN     = 36;
  localparam int FIRST   = 5;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [5:0] base;
  logic [2:0] blk_num;
  logic       stall_eff;
`ifdef MD_FETCH_CTRL_STALL_EN
  logic       stall = 1'b0;
  assign stall_eff = stall;
`else
  assign stall_eff = 1'b0;
`endif

  logic [1:0] busy_w, rd_en_w, xv_w, xf_w, xl_w, done_w;
  logic [5:0] addr_w [2];
  logic [5:0] cnt_w  [2];

  int n_vec = 0;
  int n_err = 0;
  int nwin  = 0;
  int ndone = 0;

  always #5 clk = ~clk;

  md_fetch_ctrl #(.ADDR_W(6), .RD_LAT(1), .BLK_W(3)) dut1 (
    .clk(clk), .rstn(rstn), .start_i(start), .base_i(base), .blk_num_i(blk_num),
    .busy_o(busy_w[0]), .rf_rd_en_o(rd_en_w[0]), .rf_rd_addr_o(addr_w[0]),
    .cnt_o(cnt_w[0]), .x_vld_o(xv_w[0]), .blk_first_o(xf_w[0]),
    .blk_last_o(xl_w[0]), .done_o(done_w[0])
`ifdef MD_FETCH_CTRL_STALL_EN
    , .stall_i(stall)
`endif
  );

  md_fetch_ctrl #(.ADDR_W(6), .RD_LAT(3), .BLK_W(3)) dut3 (
    .clk(clk), .rstn(rstn), .start_i(start), .base_i(base), .blk_num_i(blk_num),
    .busy_o(busy_w[1]), .rf_rd_en_o(rd_en_w[1]), .rf_rd_addr_o(addr_w[1]),
    .cnt_o(cnt_w[1]), .x_vld_o(xv_w[1]), .blk_first_o(xf_w[1]),
    .blk_last_o(xl_w[1]), .done_o(done_w[1])
`ifdef MD_FETCH_CTRL_STALL_EN
    , .stall_i(stall)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Job model: m_pos is the position inside the current block (0 = RF read,
  // LAT.. = windows), -1 outside a block; m_done marks the completion cycle.
  int m_pos  [2];
  int m_blk  [2];
  int m_nblk [2];
  int m_base [2];
  bit m_done [2];
  bit m_xv   [2];
  bit m_xf   [2];
  bit m_xl   [2];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 2; k++) begin
        m_pos[k] <= -1; m_blk[k] <= 0; m_nblk[k] <= 0; m_base[k] <= 0;
        m_done[k] <= 1'b0; m_xv[k] <= 1'b0; m_xf[k] <= 1'b0; m_xl[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_xv[k]   <= (m_pos[k] >= LAT[k]) && !stall_eff;
        m_xf[k]   <= (m_pos[k] == LAT[k]) && !stall_eff;
        m_xl[k]   <= (m_pos[k] == LAT[k] + WIN - 1) && !stall_eff;
        m_done[k] <= 1'b0;
        if (m_pos[k] < 0) begin
          if (start && !m_done[k]) begin
            m_base[k] <= int'(base);
            m_nblk[k] <= int'(blk_num) + 1;
            m_blk[k]  <= 0;
            m_pos[k]  <= 0;
          end
        end else if (m_pos[k] < LAT[k]) begin
          m_pos[k] <= m_pos[k] + 1;
        end else if (!stall_eff) begin
          if (m_pos[k] == LAT[k] + WIN - 1) begin
            if (m_blk[k] + 1 == m_nblk[k]) begin
              m_pos[k]  <= -1;
              m_done[k] <= 1'b1;
            end else begin
              m_blk[k] <= m_blk[k] + 1;
              m_pos[k] <= 0;
            end
          end else begin
            m_pos[k] <= m_pos[k] + 1;
          end
        end
      end
    end
  end

  function automatic logic [17:0] exp_vec(input int k);
    logic [5:0] a, c;
    logic       busy;
    a    = (m_pos[k] == 0) ? 6'((m_base[k] + m_blk[k]) % 64) : 6'd0;
    c    = (m_pos[k] >= LAT[k]) ? 6'(FIRST + m_pos[k] - LAT[k]) : 6'd0;
    busy = (m_pos[k] >= 0) || m_done[k];
    return {busy, (m_pos[k] == 0), a, c, m_xv[k], m_xf[k], m_xl[k], m_done[k]};
  endfunction

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++)
      check($sformatf("lat%0d outputs {busy,rd,addr,cnt,xv,xf,xl,done}", LAT[k]),
            32'({busy_w[k], rd_en_w[k], addr_w[k], cnt_w[k], xv_w[k], xf_w[k], xl_w[k], done_w[k]}),
            32'(exp_vec(k)));
  end

  // Event counters for the RD_LAT=1 instance
  always @(negedge clk) begin
    if (xv_w[0])   nwin++;
    if (done_w[0]) ndone++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b1; base = '0; blk_num = '0;
    step(3);
    check("reset busy", 32'(busy_w), 0);
    check("reset rd_en", 32'(rd_en_w), 0);
    check("reset cnt", 32'(cnt_w[0]), 0);
    check("reset x_vld", 32'(xv_w), 0);
    check("reset done", 32'(done_w), 0);
    start = 1'b0; rstn = 1'b1;
    step(3);
    check("idle busy after release", 32'(busy_w), 0);

    // Single block, base 3: T0 start
    start = 1'b1; base = 6'd3; blk_num = 3'd0;
    step(1); start = 1'b0;                                   // T1
    check("t1 rd_en", 32'(rd_en_w), 32'h3);
    check("t1 addr", 32'(addr_w[0]), 3);
    check("t1 busy", 32'(busy_w[0]), 1);
    step(1);                                                 // T2
    check("t2 cnt", 32'(cnt_w[0]), 5);
    check("t2 x_vld", 32'(xv_w[0]), 0);
    step(1);                                                 // T3
    check("t3 x_vld/first", 32'({xv_w[0], xf_w[0]}), 32'h3);
    step(1);                                                 // T4
    check("lat3 t4 cnt", 32'(cnt_w[1]), 5);
    step(33);                                                // T37
    check("t37 cnt", 32'(cnt_w[0]), 40);
    step(1);                                                 // T38
    check("t38 last/done", 32'({xv_w[0], xl_w[0], done_w[0]}), 32'h7);
    step(1);                                                 // T39
    check("t39 busy", 32'(busy_w[0]), 0);
    step(1);                                                 // T40
    check("lat3 t40 done", 32'(done_w[1]), 1);
    step(3);

    // Four blocks wrapping at 2^6, with ignored start pulses at T5 and T20
    nwin = 0;
    start = 1'b1; base = 6'd62; blk_num = 3'd3;
    step(1); start = 1'b0;                                   // T1
    check("4blk addr t1", 32'(addr_w[0]), 62);
    step(4); start = 1'b1;                                   // T5
    step(1); start = 1'b0;                                   // T6
    step(14); start = 1'b1;                                  // T20
    step(1); start = 1'b0;                                   // T21
    step(17);                                                // T38
    check("4blk addr t38", 32'({rd_en_w[0], addr_w[0]}), 32'h7f);
    step(37);                                                // T75
    check("4blk addr t75", 32'({rd_en_w[0], addr_w[0]}), 32'h40);
    step(37);                                                // T112
    check("4blk addr t112", 32'({rd_en_w[0], addr_w[0]}), 32'h41);
    step(37);                                                // T149
    check("4blk done t149", 32'(done_w[0]), 1);
    step(1);                                                 // T150
    check("4blk windows", 32'(nwin), 144);
    check("4blk idle t150", 32'(busy_w[0]), 0);
    step(12);

    // start held high: one IDLE cycle between DONE and next READ
    start = 1'b1; base = 6'd20; blk_num = 3'd0;
    step(38);                                                // T38
    check("b2b done t38", 32'(done_w[0]), 1);
    step(1);                                                 // T39
    check("b2b idle t39", 32'({busy_w[0], rd_en_w[0]}), 0);
    step(1); start = 1'b0;                                   // T40
    check("b2b read t40", 32'({rd_en_w[0], addr_w[0]}), 32'h54);
    step(42);

    // Asynchronous reset mid-job at cnt 20
    ndone = 0;
    start = 1'b1; base = 6'd10; blk_num = 3'd1;
    step(1); start = 1'b0;                                   // T1
    step(16);                                                // T17
    check("pre-reset cnt", 32'(cnt_w[0]), 20);
    #2 rstn = 1'b0;
    #1;
    check("async reset busy", 32'(busy_w), 0);
    check("async reset cnt", 32'({cnt_w[0], cnt_w[1]}), 0);
    check("async reset x_vld", 32'(xv_w), 0);
    @(negedge clk); rstn = 1'b1;
    step(80);
    check("no done after reset", 32'(ndone), 0);
    check("idle after reset", 32'(busy_w), 0);

`ifdef MD_FETCH_CTRL_STALL_EN
    // Stall for 3 cycles at cnt 12
    nwin = 0;
    start = 1'b1; base = 6'd5; blk_num = 3'd0;
    step(1); start = 1'b0;                                   // T1
    step(8);                                                 // T9
    check("stall cnt t9", 32'(cnt_w[0]), 12);
    stall = 1'b1;
    step(2);                                                 // T11
    check("stall hold", 32'({cnt_w[0], xv_w[0]}), 32'(12 << 1));
    step(1); stall = 1'b0;                                   // T12
    check("stall cnt t12", 32'(cnt_w[0]), 12);
    step(26);                                                // T38
    check("stall no done t38", 32'(done_w[0]), 0);
    step(3);                                                 // T41
    check("stall done t41", 32'(done_w[0]), 1);
    step(1);
    check("stall windows", 32'(nwin), WIN);
    step(8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/md_fetch_ctrl.md
Name: md_fetch_ctrl

Overview:
Sequencer for the intra mode-decision prefilter fetch stage. On a job request it reads N consecutive 512-bit (8x8 pixel) lines from the block register file. For each line it drives the fetch window counter through 5..40, producing 36 3x3 windows per 8x8 block. It also emits window-valid and block-boundary strobes aligned to the fetch stage's registered outputs, and pulses done at job end.

Parameters:
ADDR_W, 6, register-file line address width
RD_LAT, 1, cycles from rf_rd_en_o to valid rf_512bit data (legal 1..4)
BLK_W, 3, width of blk_num_i; a job covers blk_num_i+1 blocks (1..8)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start_i  in  1  job request, sampled only in IDLE
base_i  in  ADDR_W  first RF line of job, latched on accepted start
blk_num_i  in  BLK_W  block count minus one, latched on accepted start
busy_o  out  1  high in every state except IDLE
rf_rd_en_o  out  1  one-cycle RF read strobe
rf_rd_addr_o  out  ADDR_W  RF line address, valid with rf_rd_en_o
cnt_o  out  6  window index to fetch stage; 5..40 in SCAN, else 0
x_vld_o  out  1  fetch outputs x1/x2/x3 hold a valid window this cycle
blk_first_o  out  1  with x_vld_o: first window (cnt 5) of a block
blk_last_o  out  1  with x_vld_o: last window (cnt 40) of a block
done_o  out  1  one-cycle job-complete pulse
stall_i  in  1  downstream hold; present only with the optional macro

Behaviour:
- Reset: state IDLE. All outputs 0. Internal block index, latched base, latched count and cnt are 0. Reset is asynchronous and takes effect immediately, including mid-job. Any partial job is discarded; no done_o is produced for it.
- The state register is a one-hot or binary encoding of IDLE, READ, WAIT, SCAN, DONE.
- IDLE: if start_i=1, latch base_i and blk_num_i, clear the block index, and go to READ. busy_o rises in the following cycle.
- READ (1 cycle): rf_rd_en_o=1, rf_rd_addr_o = base + block index. The address adds modulo 2^ADDR_W with wrap and no error. Next state is WAIT if RD_LAT>1, else SCAN.
- WAIT: lasts RD_LAT-1 cycles, counted by a down-counter, then go to SCAN.
- SCAN: cnt_o starts at 5 and increments each cycle up to 40. At cnt_o=40, if block index equals the latched count, go to DONE; otherwise increment the block index and go to READ.
- DONE (1 cycle): done_o=1, then go to IDLE.
- start_i in any state other than IDLE is ignored. It is not queued.
- Outputs rf_rd_en_o, rf_rd_addr_o, cnt_o and done_o are registered, decoded from the state register.
- Pipeline alignment: x_vld_o, blk_first_o and blk_last_o are registered copies of the issue condition (SCAN, and cnt 5 / cnt 40 for the boundary strobes). This delays them one cycle, matching the fetch stage's register.
- The last x_vld_o/blk_last_o of a job coincides with done_o.
- Cycle count per job: (blk_num_i+1)*(36+RD_LAT) cycles from the first READ to the last SCAN cycle, plus DONE.
- The RF line is not re-read during SCAN. rf_512bit is required to stay stable from the data-valid cycle until the end of SCAN.

Optional Feature:
MD_FETCH_CTRL_STALL_EN
- Defined: port stall_i exists. In SCAN with stall_i=1, cnt_o holds its value and the issue condition is 0, so x_vld_o is 0 one cycle later. A window is issued only in a SCAN cycle with stall_i=0. The SCAN exit check uses the issued cnt=40. stall_i outside SCAN has no effect.
- Undefined: no stall_i port; SCAN never holds.

Decomposition:
- Shared package md_pkg holds the state encoding, MD_CNT_FIRST=5, MD_CNT_LAST=40 and MD_WIN_PER_BLK=36. The fetch stage and prefilter accumulators use the same constants.
- One natural sub-module: md_fetch_align. It is the one-cycle register stage producing x_vld_o, blk_first_o and blk_last_o from the issue strobes. It is reusable if the fetch stage gains pipeline depth.

Test Plan:
- Reset: hold rstn=0 with start_i=1 -> all outputs 0; after release, busy_o stays 0 until start_i is sampled in IDLE.
- Single block, RD_LAT=1, base=3, blk_num=0, start at T0 -> rf_rd_en/addr=3 at T1; cnt_o 5..40 over T2..T37; x_vld_o T3..T38; blk_first T3; blk_last and done T38; busy T1..T38.
- Four blocks, base=62, ADDR_W=6 -> addresses 62, 63, 0, 1 at T1, T38, T75, T112; 144 x_vld pulses; done at T149.
- RD_LAT=3, one block -> rf_rd_en at T1, first cnt_o=5 at T4, done at T40.
- Start pulses at T5 and T20 during a busy job -> ignored; start_i held high continuously -> jobs back to back with exactly one IDLE cycle between DONE and the next READ.
- Reset asserted at cnt_o=20 -> outputs 0 immediately; no done_o. With MD_FETCH_CTRL_STALL_EN, stall_i=1 for 3 cycles at cnt_o=12 -> cnt_o holds 12; x_vld_o low 3 cycles; done delayed by 3; still exactly 36 windows.
